reg_file_wb: RTL and testbench
==============================

REG_FILE_WB -- requirements
Module: reg_file_wb

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, meaning width of each register and of the write-back data.
REQ-002 SHALL provide parameter BYPASS, default 1, meaning read ports return same-cycle write data (write-through) when 1.
REQ-003 SHALL provide port clk_i  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL provide port rst_i  input  1  asynchronous active-low reset.
REQ-005 SHALL provide port rs_addr_i  input  5  read port A address.
REQ-006 SHALL provide port rt_addr_i  input  5  read port B address.
REQ-007 SHALL provide port rs_data_o  output  DATA_W  read port A data, combinational.
REQ-008 SHALL provide port rt_data_o  output  DATA_W  read port B data, combinational.
REQ-009 SHALL provide port issue_i  input  1  an instruction with a destination register issues this cycle.
REQ-010 SHALL provide port issue_rd_i  input  5  destination register of the issuing instruction.
REQ-011 SHALL provide port wb_we_i  input  1  write-back enable from the 4-to-1 write-back select stage.
REQ-012 SHALL provide port wb_rd_i  input  5  write-back destination register.
REQ-013 SHALL provide port wb_data_i  input  DATA_W  selected write-back data (ALU / memory / PC+4 / immediate).
REQ-014 SHALL provide port stall_o  output  1  a source operand (rs or rt) is pending write-back.
REQ-015 SHALL provide port busy_o  output  32  pending-write scoreboard, bit n = register n pending.

Function
REQ-016 SHALL hold 32 registers of DATA_W bits; register 0 SHALL always read 0 and SHALL ignore writes.
REQ-017 SHALL write wb_data_i into register wb_rd_i on the rising clk_i edge when wb_we_i=1 and wb_rd_i!=0.
REQ-018 SHALL, when BYPASS=1, drive rs_data_o/rt_data_o with wb_data_i when wb_we_i=1 and the read address equals wb_rd_i!=0; otherwise the stored value.
REQ-019 SHALL, when BYPASS=0, return only stored values (new data visible the cycle after the write).
REQ-020 SHALL set busy bit issue_rd_i on the clock edge when issue_i=1 and issue_rd_i!=0.
REQ-021 SHALL clear busy bit wb_rd_i on the clock edge when wb_we_i=1.
REQ-022 SHALL, when issue and write-back target the same register in the same cycle, leave that busy bit set (issue wins).
REQ-023 SHALL never set busy bit 0.
REQ-024 SHALL assert stall_o combinationally when busy[rs_addr_i] or busy[rt_addr_i] is 1, except a bit being cleared this cycle by wb_we_i SHALL NOT stall when BYPASS=1.
REQ-025 SHALL produce a write-back with a clear busy bit without error (no side effect besides the data write).

Reset
REQ-026 SHALL, while rst_i=0, asynchronously clear all registers to 0 and busy_o to 0; stall_o SHALL then be 0.
REQ-027 SHALL discard any issue or write-back presented in a cycle where rst_i=0; operation resumes at the first rising edge after rst_i deasserts.

Structure
REQ-028 SHALL place the register-count constant (32), address width (5) and zero-register index in a shared package.
REQ-029 SHALL implement the scoreboard as one sub-module named busy_scoreboard; storage and bypass stay in the top module.

Verification
REQ-030 SHALL cover reset: drive rst_i=0 mid-run after writes -> all reads 0, busy_o=0, stall_o=0.
REQ-031 SHALL cover write/read: wb_we_i=1, wb_rd_i=5, wb_data_i=0x1234_5678 -> rs_addr_i=5 reads 0x1234_5678 next cycle (same cycle with BYPASS=1).
REQ-032 SHALL cover x0: write 0xFFFF_FFFF to register 0 -> reads 0, busy_o[0]=0 even with issue_rd_i=0.
REQ-033 SHALL cover scoreboard: issue rd=7, then rs_addr_i=7 -> stall_o=1 until write-back to 7; cycle of write-back with BYPASS=1 -> stall_o=0 and rs_data_o=wb_data_i.
REQ-034 SHALL cover collision: issue rd=9 and write-back rd=9 same cycle -> busy_o[9]=1 after edge, register 9 holds written data.
REQ-035 SHALL cover dual read: rs=rt=3 holding 0xA5A5_A5A5 -> both outputs 0xA5A5_A5A5.

Source files
------------

// File: rtl/reg_file_wb_pkg.sv
// Shared constants and helpers for the write-back register file and its scoreboard.
package reg_file_wb_pkg;

   localparam int                NUM_REGS = 32;
   localparam int                ADDR_W   = 5;
   localparam logic [ADDR_W-1:0] ZERO_REG = '0;

   // One-hot mask selecting a single register index.
   function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [ADDR_W-1:0] idx);
      reg_onehot      = '0;
      reg_onehot[idx] = 1'b1;
   endfunction

endpackage

// File: rtl/reg_file_wb_busy_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register.
// Issue sets the destination bit, write-back clears it; when both hit the
// same register in one cycle the set wins, because the newer instruction
// still owes a result. Register 0 is never marked busy.
module busy_scoreboard
   import reg_file_wb_pkg::*;
#(
   parameter int BYPASS = 1
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                issue_i,
   input  logic [ADDR_W-1:0]   issue_rd_i,
   input  logic                wb_we_i,
   input  logic [ADDR_W-1:0]   wb_rd_i,
   input  logic [ADDR_W-1:0]   rs_addr_i,
   input  logic [ADDR_W-1:0]   rt_addr_i,
   output logic [NUM_REGS-1:0] busy_o,
   output logic                stall_o
);

   logic [NUM_REGS-1:0] busy_q;
   logic [NUM_REGS-1:0] busy_d;
   logic [NUM_REGS-1:0] set_mask;
   logic [NUM_REGS-1:0] clr_mask;
   logic [NUM_REGS-1:0] stall_view;

   // Next busy vector: clear on write-back, then set on issue so issue wins.
   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      if (issue_i && (issue_rd_i != ZERO_REG)) begin
         set_mask = reg_onehot(issue_rd_i);
      end
      if (wb_we_i) begin
         clr_mask = reg_onehot(wb_rd_i);
      end
      busy_d = ((busy_q & ~clr_mask) | set_mask) & ~reg_onehot(ZERO_REG);
   end

   // Operand hazard: with bypass, a result arriving this cycle already satisfies the read.
   always_comb begin
      stall_view = busy_q;
      if (BYPASS != 0) begin
         stall_view = busy_q & ~clr_mask;
      end
      stall_o = stall_view[rs_addr_i] | stall_view[rt_addr_i];
   end

   // Busy vector register, cleared asynchronously by reset.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   assign busy_o = busy_q;

endmodule

// File: rtl/reg_file_wb.sv
// 32-entry register file with write-back port, optional write-through bypass
// on both read ports, and a pending-write scoreboard that raises stall_o.
// Interface semantics: issue_i/issue_rd_i and wb_we_i/wb_rd_i/wb_data_i are
// single-cycle strobes sampled on the rising clk_i edge; there is no back-
// pressure, the producer must hold off itself while stall_o is high.
module reg_file_wb
   import reg_file_wb_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int BYPASS = 1
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [ADDR_W-1:0]   rs_addr_i,
   input  logic [ADDR_W-1:0]   rt_addr_i,
   output logic [DATA_W-1:0]   rs_data_o,
   output logic [DATA_W-1:0]   rt_data_o,
   input  logic                issue_i,
   input  logic [ADDR_W-1:0]   issue_rd_i,
   input  logic                wb_we_i,
   input  logic [ADDR_W-1:0]   wb_rd_i,
   input  logic [DATA_W-1:0]   wb_data_i,
   output logic                stall_o,
   output logic [NUM_REGS-1:0] busy_o
);

   logic [DATA_W-1:0] regs_q [NUM_REGS];
   logic              wr_en;
   logic              byp_en;

   assign wr_en  = wb_we_i && (wb_rd_i != ZERO_REG);
   assign byp_en = wr_en && (BYPASS != 0);

   // Register storage; register 0 is never written so it stays 0.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else if (wr_en) begin
         regs_q[wb_rd_i] <= wb_data_i;
      end
   end

   // Read ports: zero register, then write-through hit, then stored value.
   always_comb begin
      rs_data_o = regs_q[rs_addr_i];
      rt_data_o = regs_q[rt_addr_i];
      if (byp_en && (rs_addr_i == wb_rd_i)) begin
         rs_data_o = wb_data_i;
      end
      if (byp_en && (rt_addr_i == wb_rd_i)) begin
         rt_data_o = wb_data_i;
      end
      if (rs_addr_i == ZERO_REG) begin
         rs_data_o = '0;
      end
      if (rt_addr_i == ZERO_REG) begin
         rt_data_o = '0;
      end
   end

   busy_scoreboard #(
      .BYPASS (BYPASS)
   ) u_busy_scoreboard (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .issue_i    (issue_i),
      .issue_rd_i (issue_rd_i),
      .wb_we_i    (wb_we_i),
      .wb_rd_i    (wb_rd_i),
      .rs_addr_i  (rs_addr_i),
      .rt_addr_i  (rt_addr_i),
      .busy_o     (busy_o),
      .stall_o    (stall_o)
   );

endmodule

// File: tb/tb_reg_file_wb.sv
// Bench for reg_file_wb: one instance with bypass, one without, both fed the
// same stimulus and checked against an array-based model of the register file.
module tb_reg_file_wb;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [4:0]  rs_addr, rt_addr, issue_rd, wb_rd;
   logic        issue, wb_we;
   logic [31:0] wb_data;

   logic [31:0] rs_b, rt_b, rs_n, rt_n;
   logic [31:0] busy_b, busy_n;
   logic        stall_b, stall_n;

   reg_file_wb #(.DATA_W(32), .BYPASS(1)) dut_byp (
      .clk_i(clk), .rst_i(rst_n),
      .rs_addr_i(rs_addr), .rt_addr_i(rt_addr),
      .rs_data_o(rs_b), .rt_data_o(rt_b),
      .issue_i(issue), .issue_rd_i(issue_rd),
      .wb_we_i(wb_we), .wb_rd_i(wb_rd), .wb_data_i(wb_data),
      .stall_o(stall_b), .busy_o(busy_b)
   );

   reg_file_wb #(.DATA_W(32), .BYPASS(0)) dut_nob (
      .clk_i(clk), .rst_i(rst_n),
      .rs_addr_i(rs_addr), .rt_addr_i(rt_addr),
      .rs_data_o(rs_n), .rt_data_o(rt_n),
      .issue_i(issue), .issue_rd_i(issue_rd),
      .wb_we_i(wb_we), .wb_rd_i(wb_rd), .wb_data_i(wb_data),
      .stall_o(stall_n), .busy_o(busy_n)
   );

   // ---------------- reference model ----------------
   logic [31:0] m_regs [32];
   bit          m_busy [32];

   int tests_run = 0;
   int fail_cnt  = 0;

   function automatic logic [31:0] exp_read(input logic [4:0] a, input bit byp);
      if (a == 0) return 32'h0;
      if (byp && wb_we && wb_rd == a) return wb_data;
      return m_regs[a];
   endfunction

   function automatic logic exp_stall(input bit byp);
      bit pend_s, pend_t;
      pend_s = m_busy[rs_addr];
      pend_t = m_busy[rt_addr];
      if (byp && wb_we && wb_rd == rs_addr) pend_s = 0;
      if (byp && wb_we && wb_rd == rt_addr) pend_t = 0;
      return pend_s | pend_t;
   endfunction

   function automatic logic [31:0] exp_busy();
      logic [31:0] v;
      for (int i = 0; i < 32; i++) v[i] = m_busy[i];
      return v;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 32; i++) begin
         m_regs[i] = 32'h0;
         m_busy[i] = 0;
      end
   endtask

   // ---------------- scoreboard ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         fail_cnt++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // ---------------- driver ----------------
   // Drive one cycle of inputs after the falling edge, check all outputs,
   // then let the rising edge commit and advance the model.
   task automatic step(input logic rst, input logic iss, input logic [4:0] ird,
                       input logic we, input logic [4:0] wrd, input logic [31:0] wd,
                       input logic [4:0] ra, input logic [4:0] rb);
      @(negedge clk);
      rst_n    = rst;
      issue    = iss;
      issue_rd = ird;
      wb_we    = we;
      wb_rd    = wrd;
      wb_data  = wd;
      rs_addr  = ra;
      rt_addr  = rb;
      if (!rst) model_clear();
      #1;
      check("rs_byp",    rs_b,            exp_read(ra, 1));
      check("rt_byp",    rt_b,            exp_read(rb, 1));
      check("rs_nob",    rs_n,            exp_read(ra, 0));
      check("rt_nob",    rt_n,            exp_read(rb, 0));
      check("stall_byp", {31'b0, stall_b}, {31'b0, exp_stall(1)});
      check("stall_nob", {31'b0, stall_n}, {31'b0, exp_stall(0)});
      check("busy_byp",  busy_b,          exp_busy());
      check("busy_nob",  busy_n,          exp_busy());
      @(posedge clk);
      if (rst) begin
         if (we && wrd != 0) m_regs[wrd] = wd;
         if (we) m_busy[wrd] = 0;
         if (iss && ird != 0) m_busy[ird] = 1;
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      issue = 0; issue_rd = 0; wb_we = 0; wb_rd = 0; wb_data = 0;
      rs_addr = 0; rt_addr = 0;
      model_clear();

      // Reset: outputs quiet, strobes during reset are discarded.
      step(0, 1, 5'd4, 1, 5'd6, 32'hDEAD_BEEF, 5'd4, 5'd5);
      step(0, 1, 5'd4, 1, 5'd6, 32'hDEAD_BEEF, 5'd4, 5'd5);
      step(1, 0, 5'd0, 0, 5'd0, 32'h0,         5'd6, 5'd4);

      // Write/read register 5, same cycle (bypass) and next cycle.
      step(1, 0, 5'd0, 1, 5'd5, 32'h1234_5678, 5'd5, 5'd1);
      step(1, 0, 5'd0, 0, 5'd0, 32'h0,         5'd5, 5'd5);

      // x0: write and issue to register 0 are ignored.
      step(1, 1, 5'd0, 1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
      step(1, 0, 5'd0, 0, 5'd0, 32'h0,         5'd0, 5'd0);

      // Scoreboard: issue 7, stall while pending, write-back resolves.
      step(1, 1, 5'd7, 0, 5'd0, 32'h0,         5'd1, 5'd2);
      step(1, 0, 5'd0, 0, 5'd0, 32'h0,         5'd7, 5'd2);
      step(1, 0, 5'd0, 0, 5'd0, 32'h0,         5'd2, 5'd7);
      step(1, 0, 5'd0, 1, 5'd7, 32'hCAFE_0007, 5'd7, 5'd2);
      step(1, 0, 5'd0, 0, 5'd0, 32'h0,         5'd7, 5'd7);

      // Write-back to a register that was not pending.
      step(1, 0, 5'd0, 1, 5'd11, 32'h0000_0B0B, 5'd11, 5'd0);

      // Collision: issue and write-back to 9 together, issue wins.
      step(1, 1, 5'd9, 1, 5'd9, 32'h9999_0009, 5'd9, 5'd0);
      step(1, 0, 5'd0, 0, 5'd0, 32'h0,         5'd9, 5'd9);
      step(1, 0, 5'd0, 1, 5'd9, 32'h0909_0909, 5'd9, 5'd9);

      // Dual read of the same register.
      step(1, 0, 5'd0, 1, 5'd3, 32'hA5A5_A5A5, 5'd0, 5'd0);
      step(1, 0, 5'd0, 0, 5'd0, 32'h0,         5'd3, 5'd3);

      // Randomized traffic.
      for (int n = 0; n < 300; n++) begin
         step(1,
              ($urandom_range(0, 9) < 4),
              5'($urandom_range(0, 31)),
              ($urandom_range(0, 1) == 1),
              5'($urandom_range(0, 31)),
              32'($urandom),
              5'($urandom_range(0, 31)),
              5'($urandom_range(0, 31)));
      end

      // Mid-run reset after writes: everything returns to 0.
      step(1, 1, 5'd12, 1, 5'd13, 32'h1313_1313, 5'd13, 5'd12);
      step(0, 1, 5'd14, 1, 5'd15, 32'h1515_1515, 5'd13, 5'd12);
      step(1, 0, 5'd0, 0, 5'd0, 32'h0,          5'd13, 5'd15);
      step(1, 0, 5'd0, 0, 5'd0, 32'h0,          5'd3,  5'd5);

      $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
      $finish;
   end

endmodule
